// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 host-side blocks: transmitter state
// encoding, keyboard command bytes and LED mask bit positions.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        SEND,
        ACK_WAIT,
        IDLE_WAIT
    } ps2_tx_state_t;

    localparam logic [7:0] CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] CMD_RESEND   = 8'hFE;
    localparam logic [7:0] RESP_ACK     = 8'hFA;

    localparam int LED_SCROLL = 0;
    localparam int LED_NUM    = 1;
    localparam int LED_CAPS   = 2;

    // PS/2 frames carry odd parity over the 8 data bits
    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// PS/2 pad conditioning: 2-flop synchronisers on clock and data, a
// run-length debounce on the clock and a one-cycle falling-edge event.
// Shared with the PS/2 receiver.
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic clk_raw_i,
    input  logic data_raw_i,
    output logic clk_filt_o,
    output logic data_sync_o,
    output logic fall_evt_o
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam logic [FW-1:0] FLT_LAST = FW'(FILTER_LEN - 1);

    logic [1:0]    clk_sync_q;
    logic [1:0]    data_sync_q;
    logic          clk_filt_q;
    logic [FW-1:0] flt_cnt_q;
    logic          fall_q;

    // Synchronise both pads, then flip the filtered clock only after
    // FILTER_LEN consecutive samples disagree with the current level.
    // Lines idle high, so everything resets to 1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            clk_filt_q  <= 1'b1;
            flt_cnt_q   <= '0;
            fall_q      <= 1'b0;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], clk_raw_i};
            data_sync_q <= {data_sync_q[0], data_raw_i};
            fall_q      <= 1'b0;
            if (clk_sync_q[1] == clk_filt_q) begin
                flt_cnt_q <= '0;
            end else if (flt_cnt_q == FLT_LAST) begin
                clk_filt_q <= clk_sync_q[1];
                flt_cnt_q  <= '0;
                // only a 1->0 flip is an event
                fall_q     <= clk_filt_q;
            end else begin
                flt_cnt_q <= flt_cnt_q + 1'b1;
            end
        end
    end

    assign clk_filt_o  = clk_filt_q;
    assign data_sync_o = data_sync_q[1];
    assign fall_evt_o  = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter. Inhibits the bus, issues a
// request-to-send, shifts out one byte plus odd parity on device clock
// falling edges, checks the device ACK and waits for the bus to go idle.
// Pads are open-collector; the *_oe outputs are active-high pull-low enables.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 10000,
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_err
);

    localparam int IW = $clog2(INHIBIT_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IW-1:0] INH_LAST  = IW'(INHIBIT_CYCLES - 1);
    // The fall_evt cycle is the first cycle of the timeout window, so the
    // error pulse lands exactly TIMEOUT_CYCLES cycles after the last event.
    localparam logic [TW-1:0] TOUT_LAST = TW'(TIMEOUT_CYCLES - 2);

    logic clk_filt;
    logic data_sync;
    logic fall_evt;

    ps2_line_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_line_filter (
        .clk         (clk),
        .reset       (reset),
        .clk_raw_i   (ps2_clk_i),
        .data_raw_i  (ps2_data_i),
        .clk_filt_o  (clk_filt),
        .data_sync_o (data_sync),
        .fall_evt_o  (fall_evt)
    );

    ps2_tx_state_t state_q;
    logic          clk_oe_q;
    logic          data_oe_q;
    logic          busy_q;
    logic          done_q;
    logic          err_q;
    logic          ack_bad_q;
    logic [3:0]    bit_cnt_q;
    logic [8:0]    shreg_q;
    logic [IW-1:0] inh_q;
    logic [TW-1:0] tout_q;

    logic [3:0]    bit_cnt_d;
    logic [IW-1:0] inh_d;
    logic [TW-1:0] tout_d;
    logic          tout_hit;

    assign bit_cnt_d = bit_cnt_q + 4'd1;
    assign inh_d     = inh_q + 1'b1;
    assign tout_d    = tout_q + 1'b1;
    assign tout_hit  = (tout_q == TOUT_LAST);

    // Transfer sequencer; all pad enables and status pulses are registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            ack_bad_q <= 1'b0;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            inh_q     <= '0;
            tout_q    <= '0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (tx_start) begin
                        shreg_q   <= {odd_parity(tx_data), tx_data};
                        bit_cnt_q <= '0;
                        inh_q     <= '0;
                        ack_bad_q <= 1'b0;
                        busy_q    <= 1'b1;
                        clk_oe_q  <= 1'b1;
                        data_oe_q <= 1'b0;
                        state_q   <= INHIBIT;
                    end
                end
                INHIBIT: begin
                    if (inh_q == INH_LAST) begin
                        data_oe_q <= 1'b1;  // start bit
                        state_q   <= REQ;
                    end else begin
                        inh_q <= inh_d;
                    end
                end
                REQ: begin
                    // release clock, keep start bit; device now clocks
                    clk_oe_q <= 1'b0;
                    tout_q   <= '0;
                    state_q  <= SEND;
                end
                SEND: begin
                    if (fall_evt) begin
                        tout_q    <= '0;
                        bit_cnt_q <= bit_cnt_d;
                        if (bit_cnt_q == 4'd9) begin
                            data_oe_q <= 1'b0;  // stop bit
                            state_q   <= ACK_WAIT;
                        end else begin
                            data_oe_q <= ~shreg_q[0];
                            shreg_q   <= {1'b0, shreg_q[8:1]};
                        end
                    end else if (tout_hit) begin
                        data_oe_q <= 1'b0;
                        busy_q    <= 1'b0;
                        err_q     <= 1'b1;
                        state_q   <= IDLE;
                    end else begin
                        tout_q <= tout_d;
                    end
                end
                ACK_WAIT: begin
                    if (fall_evt) begin
                        tout_q  <= '0;
                        state_q <= IDLE_WAIT;
                        if (data_sync) begin
                            err_q     <= 1'b1;
                            ack_bad_q <= 1'b1;
                        end
                    end else if (tout_hit) begin
                        busy_q  <= 1'b0;
                        err_q   <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        tout_q <= tout_d;
                    end
                end
                IDLE_WAIT: begin
                    if (clk_filt && data_sync) begin
                        busy_q  <= 1'b0;
                        done_q  <= ~ack_bad_q;
                        state_q <= IDLE;
                    end else if (fall_evt) begin
                        tout_q <= '0;
                    end else if (tout_hit) begin
                        // a NACK already reported the error for this request
                        busy_q  <= 1'b0;
                        err_q   <= ~ack_bad_q;
                        state_q <= IDLE;
                    end else begin
                        tout_q <= tout_d;
                    end
                end
                default: begin
                    clk_oe_q  <= 1'b0;
                    data_oe_q <= 1'b0;
                    busy_q    <= 1'b0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;
    assign busy        = busy_q;
    assign tx_done     = done_q;
    assign tx_err      = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a keyboard-side BFM clocks frames out of the host
// over modelled open-collector lines and compares what it captures against
// a frame built from the byte with plain arithmetic.
module tb_ps2_host_tx;

    localparam int INH  = 20;
    localparam int FLT  = 2;
    localparam int TOUT = 400;
    localparam int HALF = 40;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] tx_data = '0;
    logic       tx_start = 1'b0;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;
    logic       ps2_clk_oe, ps2_data_oe, busy, tx_done, tx_err;
    logic       clk_line, data_line;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int done_n = 0;
    int err_n = 0;
    int last_fall = 0;

    // wired-AND bus with pull-ups
    assign clk_line  = ~(ps2_clk_oe | dev_clk_low);
    assign data_line = ~(ps2_data_oe | dev_data_low);

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .FILTER_LEN     (FLT),
        .TIMEOUT_CYCLES (TOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .tx_data     (tx_data),
        .tx_start    (tx_start),
        .ps2_clk_i   (clk_line),
        .ps2_data_i  (data_line),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe),
        .busy        (busy),
        .tx_done     (tx_done),
        .tx_err      (tx_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (tx_done) done_n <= done_n + 1;
        if (tx_err) err_n <= err_n + 1;
        if (dut.fall_evt) last_fall <= cyc;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // start bit, data LSB first, odd parity, stop bit
    function automatic logic [10:0] frame_of(input logic [7:0] d);
        int ones = 0;
        logic [10:0] f;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        f[0]    = 1'b0;
        f[8:1]  = d;
        f[9]    = (ones % 2 == 0);
        f[10]   = 1'b1;
        return f;
    endfunction

    // Issue a request and act as the device for up to nbits clock pulses
    // (10 = full frame followed by the ACK pulse).
    task automatic send_frame(input logic [7:0] d, input int nbits, input bit ack,
                              input bit glitch, input bit retry, output logic [10:0] cap);
        int inh;
        cap = '1;
        @(negedge clk);
        tx_data  = d;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        tx_data  = 8'($urandom);
        check("accept_busy", 32'(busy), 1);
        check("accept_clk_oe", 32'(ps2_clk_oe), 1);
        // window where clk is held low with data released
        inh = 0;
        while (ps2_clk_oe && !ps2_data_oe && inh < 200) begin
            inh++;
            tx_start = (retry && inh == 5);
            if (tx_start) tx_data = ~d;
            @(negedge clk);
        end
        tx_start = 1'b0;
        check("inhibit_len", inh, INH);
        check("req_clk_oe", 32'(ps2_clk_oe), 1);
        check("req_data_oe", 32'(ps2_data_oe), 1);
        @(negedge clk);
        check("send_clk_rel", 32'(ps2_clk_oe), 0);
        cap[0] = data_line;
        repeat (10) @(negedge clk);
        for (int i = 1; i <= nbits && i <= 10; i++) begin
            dev_clk_low = 1'b1;
            repeat (HALF) @(negedge clk);
            cap[i] = data_line;
            dev_clk_low = 1'b0;
            if (glitch) begin
                repeat (HALF / 2) @(negedge clk);
                dev_clk_low = 1'b1;
                @(negedge clk);
                dev_clk_low = 1'b0;
                repeat (HALF / 2 - 1) @(negedge clk);
            end else begin
                repeat (HALF) @(negedge clk);
            end
        end
        if (nbits >= 10) begin
            dev_data_low = ack;
            repeat (5) @(negedge clk);
            dev_clk_low = 1'b1;
            repeat (HALF) @(negedge clk);
            dev_clk_low = 1'b0;
            repeat (5) @(negedge clk);
            dev_data_low = 1'b0;
        end
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(busy), 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic full_send(input string tag, input logic [7:0] d, input bit ack,
                             input bit glitch, input bit retry);
        logic [10:0] cap;
        int d0, e0;
        d0 = done_n;
        e0 = err_n;
        send_frame(d, 10, ack, glitch, retry, cap);
        wait_idle({tag, "_idle"});
        check({tag, "_frame"}, 32'(cap), 32'(frame_of(d)));
        check({tag, "_done"}, done_n - d0, ack ? 1 : 0);
        check({tag, "_err"}, err_n - e0, ack ? 0 : 1);
        check({tag, "_lines"}, 32'({ps2_clk_oe, ps2_data_oe}), 0);
    endtask

    initial begin
        logic [10:0] cap;
        int d0, e0, n;

        // reset state
        repeat (3) @(negedge clk);
        check("rst_clk_oe", 32'(ps2_clk_oe), 0);
        check("rst_data_oe", 32'(ps2_data_oe), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_pulses", 32'({tx_done, tx_err}), 0);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // set-LEDs command and a small LED mask, both ACKed
        full_send("ed", 8'hED, 1'b1, 1'b0, 1'b0);
        full_send("07", 8'h07, 1'b1, 1'b0, 1'b0);

        // device withholds the ACK
        full_send("nack", 8'h00, 1'b0, 1'b0, 1'b0);

        // device stops clocking after 4 bits
        d0 = done_n;
        e0 = err_n;
        send_frame(8'($urandom), 4, 1'b1, 1'b0, 1'b0, cap);
        n = 0;
        while (!tx_err && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("tout_seen", 32'(tx_err), 1);
        check("tout_gap", cyc - last_fall, TOUT);
        check("tout_lines", 32'({ps2_clk_oe, ps2_data_oe}), 0);
        check("tout_busy", 32'(busy), 0);
        repeat (5) @(negedge clk);
        check("tout_err_cnt", err_n - e0, 1);
        check("tout_done_cnt", done_n - d0, 0);

        // reset while the device is clocking bit 5
        send_frame(8'($urandom), 5, 1'b1, 1'b0, 1'b0, cap);
        dev_clk_low = 1'b1;
        repeat (10) @(negedge clk);
        check("mid_busy", 32'(busy), 1);
        reset = 1'b1;
        #1;
        check("rst_mid_lines", 32'({ps2_clk_oe, ps2_data_oe}), 0);
        check("rst_mid_busy", 32'(busy), 0);
        dev_clk_low = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        full_send("ff", 8'hFF, 1'b1, 1'b0, 1'b0);

        // second request during INHIBIT plus short clock glitches
        full_send("glitch", 8'($urandom), 1'b1, 1'b1, 1'b1);

        // random command bytes
        for (int i = 0; i < 3; i++) begin
            full_send("rnd", 8'($urandom), 1'b1, 1'b0, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
